commit_trace_buffer: RTL
========================

// Module: commit_trace_buffer
// PURPOSE
// Parametrised hardware trace buffer for the 5-stage core. It records retired
// (writeback) instructions into a circular buffer of DEPTH entries. Recording
// supports stop-on-full or wrap modes, plus an optional PC trigger with a
// post-trigger capture count. After capture it freezes, and the entries are drained
// oldest-first over a valid/ready port. It sits beside writeback, so pipeline
// debugging needs no simulator-only $display monitors.
// PARAMETERS
// XLEN     32   data/PC width
// DEPTH    16   trace entries; power of 2, >=2
// CYCLE_W  32   width of per-entry cycle stamp
// PORTS
// clk              in   1          clock, rising edge
// reset            in   1          synchronous, active-low
// in_valid         in   1          instruction retires this cycle
// in_pc            in   XLEN       PC of retiring instruction
// in_instruction   in   32         instruction word
// in_rd            in   5          destination register
// in_write_enable  in   1          writeback enable of retiring instruction
// in_data          in   XLEN       writeback data
// cfg_arm          in   1          pulse: clear buffer, start capture
// cfg_stop_on_full in   1          1=freeze when full, 0=wrap (overwrite oldest)
// cfg_trig_en      in   1          enable PC trigger
// cfg_trig_pc      in   XLEN       trigger PC
// cfg_post_count   in   8          entries captured after trigger entry
// out_valid        out  1          entry available (DONE state only)
// out_ready        in   1          consumer accepts entry
// out_pc/out_instruction/out_rd/out_write_enable/out_data  out  as inputs  oldest entry
// out_cycle        out  CYCLE_W    cycle stamp of entry
// out_trigger      out  1          entry was the trigger instruction
// status_state     out  2          0 IDLE, 1 CAPTURE, 2 POST, 3 DONE
// status_count     out  log2(DEPTH)+1  valid entries held
// status_overflow  out  1          sticky: an entry was overwritten since arm
// BEHAVIOUR
// - Reset (reset==0 at clk edge), in any state:
//   - state=IDLE; wr_ptr, rd_ptr, count, cycle counter, post_left and overflow = 0.
//   - All out_* = 0. Storage contents are don't-care.
// - cfg_arm has highest priority in every state. It clears the pointers, count,
//   overflow and cycle counter, and enters CAPTURE. An in_valid in the arm cycle is
//   NOT recorded.
// - Cycle counter: increments every clk outside IDLE and wraps modulo 2^CYCLE_W.
//   An entry stores the counter value of its write cycle; the first cycle after arm
//   stamps 0.
// - IDLE: in_valid is ignored.
// - CAPTURE/POST: each in_valid writes one entry at wr_ptr and increments wr_ptr
//   mod DEPTH.
//   - If count<DEPTH, count increments.
//   - If count==DEPTH (wrap mode), rd_ptr also advances and overflow is set.
// - Stop mode: the write that makes count==DEPTH moves the state to DONE
//   immediately, from either CAPTURE or POST.
// - Trigger (CAPTURE only): in_valid && cfg_trig_en && in_pc==cfg_trig_pc.
//   - The entry is written with out_trigger=1 and post_left=cfg_post_count.
//   - Next state is DONE if cfg_post_count==0, else POST.
//   - A trigger match in POST or DONE is ignored.
// - POST: each recorded entry decrements post_left. The write that takes it to 0
//   enters DONE.
// - DONE: capture is frozen.
//   - out_valid = (count!=0); out_* show the entry at rd_ptr combinationally.
//   - out_valid && out_ready pops it: rd_ptr++ mod DEPTH, count--.
//   - Output data holds stable while out_valid && !out_ready.
//   - count==0 stays in DONE with out_valid=0 until cfg_arm.
// - Outside DONE: out_valid=0; out_ready is ignored.
// - First out_valid appears the cycle after entering DONE (1-cycle latency from the
//   last capture).
// - status_* are registered state/count/overflow, valid every cycle.
// TESTING
// 1 Reset held low 3 cycles while in_valid=1 -> state=0, count=0, out_valid=0,
//   overflow=0.
// 2 Arm, stop mode, DEPTH=16, 16 retires PC=0x0,0x4..0x3C:
//   - DONE after the 16th; pops return PC 0x0..0x3C in order.
//   - Cycle stamps are 0..15 for back-to-back retires; count ends 0.
// 3 Wrap mode, 20 retires PC=0x0..0x4C, trigger PC 0x4C, post=0:
//   - DONE with overflow=1, count=16.
//   - Drain yields PC 0x10..0x4C; the last entry has out_trigger=1.
// 4 Trigger PC=0x100, post=3, retires 0xF8..0x110:
//   - DONE after 0x10C; trigger flag set only on 0x100.
//   - The retire at 0x110 is not recorded.
// 5 In DONE with count=4: hold out_ready=0 for 5 cycles (outputs stable), then 1 ->
//   4 pops, then out_valid=0.
// 6 cfg_arm during POST, with in_valid=1 in the arm cycle -> count=0, state=CAPTURE,
//   that retire is not stored.

Source files
------------

// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_buffer
// Description : Trace buffer for retired (writeback) instructions. Entries go
//               into a circular buffer of DEPTH entries. Capture either stops
//               when the buffer is full or wraps and overwrites the oldest
//               entry. An optional PC trigger ends capture after a set number
//               of further entries. Once capture is frozen, entries drain
//               oldest-first over a valid/ready port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                 in   clock, rising edge
//   reset               in   synchronous, active-low
//   in_valid            in   an instruction retires this cycle
//   in_pc               in   PC of the retiring instruction
//   in_instruction      in   instruction word
//   in_rd               in   destination register
//   in_write_enable     in   writeback enable of the retiring instruction
//   in_data             in   writeback data
//   cfg_arm             in   pulse: clear the buffer and start capture
//   cfg_stop_on_full    in   1 = freeze when full, 0 = wrap
//   cfg_trig_en         in   enable the PC trigger
//   cfg_trig_pc         in   trigger PC
//   cfg_post_count      in   entries captured after the trigger entry
//   out_valid           out  entry available (DONE state only)
//   out_ready           in   consumer accepts the entry
//   out_pc .. out_data  out  fields of the oldest entry
//   out_cycle           out  cycle stamp of the oldest entry
//   out_trigger         out  the oldest entry was the trigger instruction
//   status_state        out  0 IDLE, 1 CAPTURE, 2 POST, 3 DONE
//   status_count        out  number of valid entries held
//   status_overflow     out  sticky: an entry was overwritten since arm
// ============================================================================
module commit_trace_buffer #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 16,
  parameter int CYCLE_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_instruction,
  input  logic [4:0]               in_rd,
  input  logic                     in_write_enable,
  input  logic [XLEN-1:0]          in_data,
  input  logic                     cfg_arm,
  input  logic                     cfg_stop_on_full,
  input  logic                     cfg_trig_en,
  input  logic [XLEN-1:0]          cfg_trig_pc,
  input  logic [7:0]               cfg_post_count,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_instruction,
  output logic [4:0]               out_rd,
  output logic                     out_write_enable,
  output logic [XLEN-1:0]          out_data,
  output logic [CYCLE_W-1:0]       out_cycle,
  output logic                     out_trigger,
  output logic [1:0]               status_state,
  output logic [$clog2(DEPTH):0]   status_count,
  output logic                     status_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT   = (AW+1)'(DEPTH);
  localparam logic [AW:0] ALMOST_COUNT = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t               state;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic [CYCLE_W-1:0]   cycle;
  logic [7:0]           post_left;
  logic                 overflow;

  // Entry storage; contents are never reset, validity is tracked by count.
  logic [XLEN-1:0]      mem_pc    [DEPTH];
  logic [31:0]          mem_instr [DEPTH];
  logic [4:0]           mem_rd    [DEPTH];
  logic                 mem_we    [DEPTH];
  logic [XLEN-1:0]      mem_data  [DEPTH];
  logic [CYCLE_W-1:0]   mem_cycle [DEPTH];
  logic                 mem_trig  [DEPTH];

  logic capturing;
  logic record;
  logic trig_hit;
  logic full_now;
  logic reach_full;
  logic pop;

  assign capturing  = (state == ST_CAPTURE) || (state == ST_POST);
  // An arm in the same cycle wins: the retire is dropped.
  assign record     = reset && !cfg_arm && capturing && in_valid;
  // Triggers only count while still in CAPTURE.
  assign trig_hit   = (state == ST_CAPTURE) && cfg_trig_en && (in_pc == cfg_trig_pc);
  assign full_now   = (count == FULL_COUNT);
  // The count after this write equals DEPTH (either it just filled, or it
  // was already full and the write overwrote the oldest entry).
  assign reach_full = full_now || (count == ALMOST_COUNT);
  assign pop        = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (record) begin
      mem_pc[wr_ptr]    <= in_pc;
      mem_instr[wr_ptr] <= in_instruction;
      mem_rd[wr_ptr]    <= in_rd;
      mem_we[wr_ptr]    <= in_write_enable;
      mem_data[wr_ptr]  <= in_data;
      mem_cycle[wr_ptr] <= cycle;
      mem_trig[wr_ptr]  <= trig_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cycle     <= '0;
      post_left <= '0;
      overflow  <= 1'b0;
    end else if (cfg_arm) begin
      state     <= ST_CAPTURE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cycle     <= '0;
      post_left <= '0;
      overflow  <= 1'b0;
    end else begin
      if (state != ST_IDLE) begin
        cycle <= cycle + 1'b1;
      end
      unique case (state)
        ST_CAPTURE, ST_POST: begin
          if (in_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (full_now) begin
              // Wrap: the oldest entry is lost, so the read side moves too.
              rd_ptr   <= rd_ptr + 1'b1;
              overflow <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end

            if (cfg_stop_on_full && reach_full) begin
              state <= ST_DONE;
            end else if (trig_hit) begin
              post_left <= cfg_post_count;
              state     <= (cfg_post_count == 8'd0) ? ST_DONE : ST_POST;
            end else if (state == ST_POST) begin
              post_left <= post_left - 8'd1;
              if (post_left == 8'd1) begin
                state <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Read port: the oldest entry is presented directly from storage while
  // frozen; everything reads as zero otherwise.
  always_comb begin
    out_valid        = 1'b0;
    out_pc           = '0;
    out_instruction  = '0;
    out_rd           = '0;
    out_write_enable = 1'b0;
    out_data         = '0;
    out_cycle        = '0;
    out_trigger      = 1'b0;
    if ((state == ST_DONE) && (count != '0)) begin
      out_valid        = 1'b1;
      out_pc           = mem_pc[rd_ptr];
      out_instruction  = mem_instr[rd_ptr];
      out_rd           = mem_rd[rd_ptr];
      out_write_enable = mem_we[rd_ptr];
      out_data         = mem_data[rd_ptr];
      out_cycle        = mem_cycle[rd_ptr];
      out_trigger      = mem_trig[rd_ptr];
    end
  end

  assign status_state    = state;
  assign status_count    = count;
  assign status_overflow = overflow;

endmodule
`default_nettype wire
